// File: rtl/peripheral_divider_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Address map, CTRL/status bit positions and FSM encoding for
//               the memory-mapped integer divider peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    localparam logic [4:0] CTRL           = 5'h00;
    localparam logic [4:0] DIVIDEND_BASE  = 5'h01;
    localparam logic [4:0] DIVISOR_BASE   = 5'h05;
    localparam logic [4:0] QUOTIENT_BASE  = 5'h09;
    localparam logic [4:0] REMAINDER_BASE = 5'h0D;

    // CTRL write bits
    localparam int CTRL_GO     = 0;
    localparam int CTRL_SIGNED = 1;
    localparam int CTRL_IRQ_EN = 2;

    // CTRL read (status) bits
    localparam int STAT_DONE   = 0;
    localparam int STAT_BUSY   = 1;
    localparam int STAT_DBZ    = 2;
    localparam int STAT_SIGNED = 3;
    localparam int STAT_IRQ_EN = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/peripheral_divider_n_if.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_divider_n_if
// Description : J1 16-bit I/O bus bundle for the divider peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
interface peripheral_divider_n_if;
    logic [15:0] d_in;
    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic        irq;

    modport master (
        output d_in, cs, addr, rd, wr,
        input  d_out, irq
    );

    modport slave (
        input  d_in, cs, addr, rd, wr,
        output d_out, irq
    );
endinterface
`default_nettype wire

// File: rtl/peripheral_divider_n_core.sv
`default_nettype none
// ============================================================================
// Module      : divider_core
// Description : Sequential restoring divider, one quotient bit per clock,
//               with signed magnitude handling and divide-by-zero path.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_core
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic             signed_mode,
    input  wire logic [WIDTH-1:0] dividend,
    input  wire logic [WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done_pulse,
    output logic                  dbz,
    output logic [WIDTH-1:0]      quotient,
    output logic [WIDTH-1:0]      remainder
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_zero;
    logic             r_busy;
    logic             r_done_pulse;
    logic             r_dbz;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_a_neg = signed_mode & dividend[WIDTH-1];
        w_b_neg = signed_mode & divisor[WIDTH-1];
        w_a_mag = w_a_neg ? -dividend : dividend;
        w_b_mag = w_b_neg ? -divisor  : divisor;
        // Partial remainder shifted left with the next dividend bit from r_quo.
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_fits  = (w_shift >= {1'b0, r_div});
        w_diff  = w_shift[WIDTH-1:0] - r_div;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_div        <= '0;
            r_dividend   <= '0;
            r_quotient   <= '0;
            r_remainder  <= '0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_zero       <= 1'b0;
            r_busy       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_dbz        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // busy drops together with the done pulse so status never
                    // shows an idle-but-not-done gap.
                    r_done_pulse <= 1'b0;
                    if (r_done_pulse) begin
                        r_busy <= 1'b0;
                    end else if (start && !r_busy) begin
                        r_busy     <= 1'b1;
                        r_dbz      <= 1'b0;
                        r_dividend <= dividend;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_zero     <= (divisor == '0);
                        r_quo      <= w_a_mag;
                        r_div      <= w_b_mag;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_state    <= (divisor == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    r_rem <= w_fits ? w_diff : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_fits};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dividend;
                        r_dbz       <= 1'b1;
                    end else begin
                        r_quotient  <= r_neg_q ? -r_quo : r_quo;
                        r_remainder <= r_neg_r ? -r_rem : r_rem;
                    end
                    r_done_pulse <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done_pulse = r_done_pulse;
    assign dbz        = r_dbz;
    assign quotient   = r_quotient;
    assign remainder  = r_remainder;

endmodule
`default_nettype wire

// File: rtl/peripheral_divider_n.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_divider_n
// Description : Memory-mapped WIDTH-bit divider: bus decode, operand register
//               file, registered read mux and interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_divider_n
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    peripheral_divider_n_if.slave  bus
);

    localparam int NW = WIDTH / 16;

    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic             r_signed_mode;
    logic             r_irq_en;
    logic             r_done;
    logic [15:0]      r_d_out;

    logic [WIDTH-1:0] w_quotient;
    logic [WIDTH-1:0] w_remainder;
    logic             w_busy;
    logic             w_done_pulse;
    logic             w_dbz;
    logic             w_wr;
    logic             w_rd;
    logic             w_ctrl_wr;
    logic [15:0]      w_rd_data;

    assign w_wr      = bus.cs & bus.wr;
    assign w_rd      = bus.cs & bus.rd;
    assign w_ctrl_wr = w_wr && (bus.addr == CTRL);

    divider_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .start       (w_ctrl_wr & bus.d_in[CTRL_GO]),
        .signed_mode (bus.d_in[CTRL_SIGNED]),
        .dividend    (r_dividend),
        .divisor     (r_divisor),
        .busy        (w_busy),
        .done_pulse  (w_done_pulse),
        .dbz         (w_dbz),
        .quotient    (w_quotient),
        .remainder   (w_remainder)
    );

    always_comb begin
        w_rd_data = '0;
        if (bus.addr == CTRL) begin
            w_rd_data[STAT_DONE]   = r_done;
            w_rd_data[STAT_BUSY]   = w_busy;
            w_rd_data[STAT_DBZ]    = w_dbz;
            w_rd_data[STAT_SIGNED] = r_signed_mode;
            w_rd_data[STAT_IRQ_EN] = r_irq_en;
        end
        for (int k = 0; k < NW; k++) begin
            if (bus.addr == DIVIDEND_BASE + 5'(k))  w_rd_data = r_dividend[16*k +: 16];
            if (bus.addr == DIVISOR_BASE + 5'(k))   w_rd_data = r_divisor[16*k +: 16];
            if (bus.addr == QUOTIENT_BASE + 5'(k))  w_rd_data = w_quotient[16*k +: 16];
            if (bus.addr == REMAINDER_BASE + 5'(k)) w_rd_data = w_remainder[16*k +: 16];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_signed_mode <= 1'b0;
            r_irq_en      <= 1'b0;
            r_done        <= 1'b0;
            r_d_out       <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_signed_mode <= bus.d_in[CTRL_SIGNED];
                r_irq_en      <= bus.d_in[CTRL_IRQ_EN];
            end
            for (int k = 0; k < NW; k++) begin
                if (w_wr && bus.addr == DIVIDEND_BASE + 5'(k)) r_dividend[16*k +: 16] <= bus.d_in;
                if (w_wr && bus.addr == DIVISOR_BASE + 5'(k))  r_divisor[16*k +: 16]  <= bus.d_in;
            end
            // Only a go the core actually accepts clears done.
            if (w_ctrl_wr && bus.d_in[CTRL_GO] && !w_busy) begin
                r_done <= 1'b0;
            end else if (w_done_pulse) begin
                r_done <= 1'b1;
            end
            if (w_rd) begin
                r_d_out <= w_rd_data;
            end
        end
    end

    assign bus.d_out = r_d_out;
    assign bus.irq   = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_divider_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_divider_n
// Description : Directed-vector bench for the divider peripheral at WIDTH
//               32, 16 and 64 sharing one bus driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_divider_n;
    import divider_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic [4:0]  addr;
    logic        cs, rd, wr;
    int          sel;
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    peripheral_divider_n_if bus32 ();
    peripheral_divider_n_if bus16 ();
    peripheral_divider_n_if bus64 ();

    assign bus32.d_in = d_in;  assign bus32.addr = addr;  assign bus32.rd = rd;
    assign bus32.wr = wr;      assign bus32.cs = cs && (sel == 32);
    assign bus16.d_in = d_in;  assign bus16.addr = addr;  assign bus16.rd = rd;
    assign bus16.wr = wr;      assign bus16.cs = cs && (sel == 16);
    assign bus64.d_in = d_in;  assign bus64.addr = addr;  assign bus64.rd = rd;
    assign bus64.wr = wr;      assign bus64.cs = cs && (sel == 64);

    peripheral_divider_n #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    peripheral_divider_n #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    peripheral_divider_n #(.WIDTH(64)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));

    function automatic logic [15:0] cur_dout();
        case (sel)
            16:      return bus16.d_out;
            64:      return bus64.d_out;
            default: return bus32.d_out;
        endcase
    endfunction

    function automatic logic cur_irq();
        case (sel)
            16:      return bus16.irq;
            64:      return bus64.irq;
            default: return bus32.irq;
        endcase
    endfunction

    // Each bus task starts and ends on a falling edge and spans one cycle.
    task automatic bus_write(input logic [4:0] a, input logic [15:0] v);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = v;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [15:0] v);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        v = cur_dout();
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic write_op(input logic [4:0] base, input logic [63:0] v, input int nw);
        for (int k = 0; k < nw; k++) bus_write(5'(base + 5'(k)), v[16*k +: 16]);
    endtask

    task automatic read_op(input logic [4:0] base, input int nw, output logic [63:0] v);
        logic [15:0] w;
        v = '0;
        for (int k = 0; k < nw; k++) begin
            bus_read(5'(base + 5'(k)), w);
            v[16*k +: 16] = w;
        end
    endtask

    task automatic wait_irq(input int start, output int k);
        k = start;
        while (!cur_irq() && k < 300) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_div(input logic [63:0] a, input logic [63:0] b, input logic [15:0] ctrl,
                           input int nw, output int lat, output logic [63:0] q,
                           output logic [63:0] r, output logic [15:0] st);
        write_op(DIVIDEND_BASE, a, nw);
        write_op(DIVISOR_BASE, b, nw);
        bus_write(CTRL, ctrl);
        wait_irq(0, lat);
        read_op(QUOTIENT_BASE, nw, q);
        read_op(REMAINDER_BASE, nw, r);
        bus_read(CTRL, st);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        sel = 32;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({bus32.d_out, bus32.irq} !== 17'h0) begin
            errors++; $display("FAIL reset_outputs got d_out=%h irq=%b expected 0/0", bus32.d_out, bus32.irq);
        end
        bus_read(CTRL, v);
        vectors++;
        if (v !== 16'h0000) begin errors++; $display("FAIL reset_status got %h expected 0000", v); end
    endtask

    task automatic test_unsigned();
        logic [15:0] st;
        logic [63:0] q, r;
        int          lat;
        sel = 32;
        write_op(DIVIDEND_BASE, 64'd100, 2);
        write_op(DIVISOR_BASE, 64'd7, 2);
        bus_write(CTRL, 16'h0005);
        bus_read(CTRL, st);
        vectors++;
        if (st !== 16'h0012) begin errors++; $display("FAIL unsigned_busy got %h expected 0012", st); end
        wait_irq(1, lat);
        vectors++;
        if (lat !== 34) begin errors++; $display("FAIL unsigned_latency got %0d expected 34", lat); end
        read_op(QUOTIENT_BASE, 2, q);
        read_op(REMAINDER_BASE, 2, r);
        bus_read(CTRL, st);
        vectors++;
        if ({q[31:0], r[31:0], st} !== {32'h0000000E, 32'h00000002, 16'h0011}) begin
            errors++; $display("FAIL unsigned_100_7 got q=%h r=%h st=%h expected 0000000e 00000002 0011", q[31:0], r[31:0], st);
        end
    endtask

    task automatic test_signed();
        logic [15:0] st;
        logic [63:0] q, r;
        int          lat;
        sel = 32;
        run_div(64'hFFFFFF9C, 64'd7, 16'h0007, 2, lat, q, r, st);
        vectors++;
        if ({q[31:0], r[31:0], st} !== {32'hFFFFFFF2, 32'hFFFFFFFE, 16'h0019} || lat !== 34) begin
            errors++; $display("FAIL signed_m100_7 got q=%h r=%h st=%h lat=%0d expected fffffff2 fffffffe 0019 34", q[31:0], r[31:0], st, lat);
        end
        run_div(64'hFFFFFF9C, 64'd7, 16'h0005, 2, lat, q, r, st);
        vectors++;
        if ({q[31:0], r[31:0], st} !== {32'h24924916, 32'h00000002, 16'h0011}) begin
            errors++; $display("FAIL unsigned_big_7 got q=%h r=%h st=%h expected 24924916 00000002 0011", q[31:0], r[31:0], st);
        end
        run_div(64'd100, 64'hFFFFFFF9, 16'h0007, 2, lat, q, r, st);
        vectors++;
        if ({q[31:0], r[31:0]} !== {32'hFFFFFFF2, 32'h00000002}) begin
            errors++; $display("FAIL signed_100_m7 got q=%h r=%h expected fffffff2 00000002", q[31:0], r[31:0]);
        end
        run_div(64'h80000000, 64'hFFFFFFFF, 16'h0007, 2, lat, q, r, st);
        vectors++;
        if ({q[31:0], r[31:0], st} !== {32'h80000000, 32'h00000000, 16'h0019}) begin
            errors++; $display("FAIL signed_min_m1 got q=%h r=%h st=%h expected 80000000 00000000 0019", q[31:0], r[31:0], st);
        end
    endtask

    task automatic test_dbz();
        logic [15:0] st;
        logic [63:0] q, r;
        int          lat;
        sel = 32;
        run_div(64'h12345678, 64'd0, 16'h0005, 2, lat, q, r, st);
        vectors++;
        if ({q[31:0], r[31:0], st} !== {32'hFFFFFFFF, 32'h12345678, 16'h0015} || lat !== 2) begin
            errors++; $display("FAIL dbz_unsigned got q=%h r=%h st=%h lat=%0d expected ffffffff 12345678 0015 2", q[31:0], r[31:0], st, lat);
        end
        vectors++;
        if (cur_irq() !== 1'b1) begin errors++; $display("FAIL dbz_irq_set got %b expected 1", cur_irq()); end
        bus_write(CTRL, 16'h0000);
        vectors++;
        if (cur_irq() !== 1'b0) begin errors++; $display("FAIL dbz_irq_clear got %b expected 0", cur_irq()); end
        run_div(64'hFFFFFF9C, 64'd0, 16'h0007, 2, lat, q, r, st);
        vectors++;
        if ({q[31:0], r[31:0], st} !== {32'hFFFFFFFF, 32'hFFFFFF9C, 16'h001D}) begin
            errors++; $display("FAIL dbz_signed got q=%h r=%h st=%h expected ffffffff ffffff9c 001d", q[31:0], r[31:0], st);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] st, dv;
        logic [63:0] q, r;
        int          lat;
        sel = 32;
        write_op(DIVIDEND_BASE, 64'd100, 2);
        write_op(DIVISOR_BASE, 64'd7, 2);
        bus_write(CTRL, 16'h0005);
        repeat (9) @(negedge clk);
        bus_write(CTRL, 16'h0007);
        bus_write(DIVISOR_BASE, 16'd3);
        wait_irq(11, lat);
        read_op(QUOTIENT_BASE, 2, q);
        read_op(REMAINDER_BASE, 2, r);
        bus_read(CTRL, st);
        bus_read(DIVISOR_BASE, dv);
        vectors++;
        if ({q[31:0], r[31:0], st, dv} !== {32'h0000000E, 32'h00000002, 16'h0019, 16'h0003} || lat !== 34) begin
            errors++; $display("FAIL busy_ignore got q=%h r=%h st=%h div=%h lat=%0d expected 0000000e 00000002 0019 0003 34",
                               q[31:0], r[31:0], st, dv, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] st, qv, dv;
        logic [63:0] q, r;
        int          lat;
        sel = 32;
        write_op(DIVIDEND_BASE, 64'd100, 2);
        write_op(DIVISOR_BASE, 64'd7, 2);
        bus_write(CTRL, 16'h0005);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({bus32.d_out, bus32.irq} !== 17'h0) begin
            errors++; $display("FAIL midreset_outputs got d_out=%h irq=%b expected 0/0", bus32.d_out, bus32.irq);
        end
        bus_read(CTRL, st);
        bus_read(QUOTIENT_BASE, qv);
        bus_read(DIVIDEND_BASE, dv);
        vectors++;
        if ({st, qv, dv} !== 48'h0) begin
            errors++; $display("FAIL midreset_regs got st=%h q=%h dividend=%h expected 0000 0000 0000", st, qv, dv);
        end
        run_div(64'hFFFFFFFF, 64'd1, 16'h0005, 2, lat, q, r, st);
        vectors++;
        if ({q[31:0], r[31:0]} !== {32'hFFFFFFFF, 32'h00000000} || lat !== 34) begin
            errors++; $display("FAIL midreset_rerun got q=%h r=%h lat=%0d expected ffffffff 00000000 34", q[31:0], r[31:0], lat);
        end
    endtask

    task automatic test_unmapped();
        logic [15:0] v;
        logic [4:0]  holes [3] = '{5'h03, 5'h11, 5'h1F};
        sel = 32;
        bus_write(5'h03, 16'hBEEF);
        foreach (holes[i]) begin
            bus_read(DIVIDEND_BASE, v);
            bus_read(holes[i], v);
            vectors++;
            if (v !== 16'h0000) begin errors++; $display("FAIL unmapped_%h got %h expected 0000", holes[i], v); end
        end
    endtask

    task automatic test_width64();
        logic [15:0] st;
        logic [63:0] q, r;
        int          lat;
        sel = 64;
        run_div(64'h0000000100000000, 64'h10, 16'h0005, 4, lat, q, r, st);
        vectors++;
        if ({q, r, st} !== {64'h0000000010000000, 64'h0, 16'h0011} || lat !== 66) begin
            errors++; $display("FAIL w64_div got q=%h r=%h st=%h lat=%0d expected 0000000010000000 0 0011 66", q, r, st, lat);
        end
    endtask

    task automatic test_width16();
        logic [15:0] st, v, hi;
        logic [63:0] q, r;
        int          lat;
        sel = 16;
        bus_write(5'h02, 16'hABCD);
        bus_read(5'h02, v);
        vectors++;
        if (v !== 16'h0000) begin errors++; $display("FAIL w16_word1 got %h expected 0000", v); end
        run_div(64'h8000, 64'hFFFF, 16'h0007, 1, lat, q, r, st);
        bus_read(5'h0A, hi);
        vectors++;
        if ({q[15:0], r[15:0], st, hi} !== {16'h8000, 16'h0000, 16'h0019, 16'h0000} || lat !== 18) begin
            errors++; $display("FAIL w16_min_m1 got q=%h r=%h st=%h q_hi=%h lat=%0d expected 8000 0000 0019 0000 18",
                               q[15:0], r[15:0], st, hi, lat);
        end
    endtask

    initial begin
        cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0; sel = 32; rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_unsigned();
        test_signed();
        test_dbz();
        test_back_to_back();
        test_reset_mid();
        test_unmapped();
        test_width64();
        test_width16();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
